// File: rtl/escalonador_quantum.sv
// Round-robin quantum scheduler for two user processes plus the OS context.
// Emits a one-cycle dispatch code and a one-cycle return-to-OS pulse.
module escalonador_quantum #(
    parameter int NUM_PROC = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [4:0] quantum,
    input  logic       instr_retirada,
    input  logic       halt_usuario,
    input  logic       pedido_despacho,
    output logic       flag_faz_preempcao,
    output logic [1:0] jump_prog,
    output logic [1:0] processo_atual,
    output logic [4:0] contador_quantum,
    output logic [1:0] processos_vivos,
    output logic       todos_terminados
);

    typedef enum logic [1:0] {
        SO       = 2'd0,
        DESPACHO = 2'd1,
        USUARIO  = 2'd2,
        RETORNO  = 2'd3
    } estado_t;

    // Highest process id; starting from it makes the first dispatch pick P1.
    localparam logic [1:0] ULTIMO_INICIAL = NUM_PROC[1:0];

    estado_t    estado;
    logic [1:0] ultimo;
    logic [1:0] outro;
    logic [1:0] proximo;
    logic [1:0] vivos_apos_halt;

    function automatic logic [1:0] mascara(input logic [1:0] id);
        case (id)
            2'd1:    mascara = 2'b01;
            2'd2:    mascara = 2'b10;
            default: mascara = 2'b00;
        endcase
    endfunction

    // Round-robin pick: prefer the other process, fall back to the last one.
    always_comb begin
        outro           = (ultimo == 2'd1) ? 2'd2 : 2'd1;
        proximo         = 2'd0;
        vivos_apos_halt = processos_vivos & ~mascara(processo_atual);
        if ((processos_vivos & mascara(outro)) != 2'b00) begin
            proximo = outro;
        end else if ((processos_vivos & mascara(ultimo)) != 2'b00) begin
            proximo = ultimo;
        end else begin
            proximo = 2'd0;
        end
    end

    // Scheduler FSM with all outputs registered.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado             <= SO;
            ultimo             <= ULTIMO_INICIAL;
            flag_faz_preempcao <= 1'b0;
            jump_prog          <= 2'd0;
            processo_atual     <= 2'd0;
            contador_quantum   <= 5'd0;
            processos_vivos    <= 2'b11;
            todos_terminados   <= 1'b0;
        end else begin
            case (estado)
                SO: begin
                    flag_faz_preempcao <= 1'b0;
                    if (pedido_despacho && (proximo != 2'd0)) begin
                        estado         <= DESPACHO;
                        jump_prog      <= proximo;
                        processo_atual <= proximo;
                        ultimo         <= proximo;
                    end else begin
                        jump_prog <= 2'd0;
                    end
                end
                DESPACHO: begin
                    jump_prog        <= 2'd0;
                    contador_quantum <= (quantum == 5'd0) ? 5'd1 : quantum;
                    estado           <= USUARIO;
                end
                USUARIO: begin
                    if (instr_retirada && (contador_quantum != 5'd0)) begin
                        contador_quantum <= contador_quantum - 5'd1;
                    end else begin
                        contador_quantum <= contador_quantum;
                    end
                    // HALT wins over expiry but both lead to a single return.
                    if (halt_usuario) begin
                        processos_vivos    <= vivos_apos_halt;
                        todos_terminados   <= (vivos_apos_halt == 2'b00);
                        flag_faz_preempcao <= 1'b1;
                        estado             <= RETORNO;
                    end else if (instr_retirada && (contador_quantum == 5'd1)) begin
                        flag_faz_preempcao <= 1'b1;
                        estado             <= RETORNO;
                    end else begin
                        flag_faz_preempcao <= 1'b0;
                    end
                end
                RETORNO: begin
                    flag_faz_preempcao <= 1'b0;
                    jump_prog          <= 2'd0;
                    processo_atual     <= 2'd0;
                    contador_quantum   <= 5'd0;
                    estado             <= SO;
                end
                default: begin
                    estado             <= SO;
                    flag_faz_preempcao <= 1'b0;
                    jump_prog          <= 2'd0;
                    processo_atual     <= 2'd0;
                    contador_quantum   <= 5'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_escalonador_quantum.sv
// Directed self-checking bench for escalonador_quantum.
module tb_escalonador_quantum;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [4:0] quantum = 5'd0;
    logic       instr_retirada = 1'b0;
    logic       halt_usuario = 1'b0;
    logic       pedido_despacho = 1'b0;
    logic       flag_faz_preempcao;
    logic [1:0] jump_prog;
    logic [1:0] processo_atual;
    logic [4:0] contador_quantum;
    logic [1:0] processos_vivos;
    logic       todos_terminados;

    int total = 0;
    int passed = 0;

    escalonador_quantum #(.NUM_PROC(2)) dut (
        .clock(clock),
        .reset(reset),
        .quantum(quantum),
        .instr_retirada(instr_retirada),
        .halt_usuario(halt_usuario),
        .pedido_despacho(pedido_despacho),
        .flag_faz_preempcao(flag_faz_preempcao),
        .jump_prog(jump_prog),
        .processo_atual(processo_atual),
        .contador_quantum(contador_quantum),
        .processos_vivos(processos_vivos),
        .todos_terminados(todos_terminados)
    );

    always #5 clock = ~clock;

    // Advance one edge; outputs are then sampled 1 time unit after it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        instr_retirada  = 1'b0;
        halt_usuario    = 1'b0;
        pedido_despacho = 1'b0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    // Request a dispatch, check the DESPACHO cycle, then the loaded counter.
    task automatic dispatch(input logic [1:0] exp_id, input logic [4:0] exp_cnt, input string name);
        pedido_despacho = 1'b1;
        step();
        pedido_despacho = 1'b0;
        total++;
        if (jump_prog !== exp_id || processo_atual !== exp_id || flag_faz_preempcao !== 1'b0)
            $display("FAIL %s_despacho: jump=%0d proc=%0d flag=%0b, expected jump=%0d proc=%0d flag=0",
                     name, jump_prog, processo_atual, flag_faz_preempcao, exp_id, exp_id);
        else passed++;
        step();
        total++;
        if (jump_prog !== 2'd0 || contador_quantum !== exp_cnt || processo_atual !== exp_id)
            $display("FAIL %s_usuario: jump=%0d cnt=%0d proc=%0d, expected jump=0 cnt=%0d proc=%0d",
                     name, jump_prog, contador_quantum, processo_atual, exp_cnt, exp_id);
        else passed++;
    endtask

    task automatic retire(input logic [4:0] exp_cnt, input logic exp_flag, input string name);
        instr_retirada = 1'b1;
        step();
        instr_retirada = 1'b0;
        total++;
        if (contador_quantum !== exp_cnt || flag_faz_preempcao !== exp_flag || jump_prog !== 2'd0)
            $display("FAIL %s: cnt=%0d flag=%0b jump=%0d, expected cnt=%0d flag=%0b jump=0",
                     name, contador_quantum, flag_faz_preempcao, jump_prog, exp_cnt, exp_flag);
        else passed++;
    endtask

    // The cycle after RETORNO: back in the OS with everything cleared.
    task automatic check_back_in_so(input string name);
        step();
        total++;
        if (flag_faz_preempcao !== 1'b0 || processo_atual !== 2'd0 || contador_quantum !== 5'd0 || jump_prog !== 2'd0)
            $display("FAIL %s_so: flag=%0b proc=%0d cnt=%0d jump=%0d, expected 0 0 0 0",
                     name, flag_faz_preempcao, processo_atual, contador_quantum, jump_prog);
        else passed++;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step();
            total++;
            if (flag_faz_preempcao !== 1'b0 || jump_prog !== 2'd0 || processo_atual !== 2'd0 ||
                contador_quantum !== 5'd0 || processos_vivos !== 2'b11 || todos_terminados !== 1'b0)
                $display("FAIL reset_idle%0d: flag=%0b jump=%0d proc=%0d cnt=%0d vivos=%b todos=%0b, expected 0 0 0 0 11 0",
                         i, flag_faz_preempcao, jump_prog, processo_atual, contador_quantum,
                         processos_vivos, todos_terminados);
            else passed++;
        end
    endtask

    task automatic test_basic_quantum();
        do_reset();
        quantum = 5'd3;
        dispatch(2'd1, 5'd3, "basic");
        retire(5'd2, 1'b0, "basic_r1");
        retire(5'd1, 1'b0, "basic_r2");
        retire(5'd0, 1'b1, "basic_r3");
        check_back_in_so("basic");
    endtask

    task automatic test_round_robin();
        logic [1:0] seq [3];
        seq[0] = 2'd1;
        seq[1] = 2'd2;
        seq[2] = 2'd1;
        do_reset();
        quantum = 5'd2;
        for (int i = 0; i < 3; i++) begin
            dispatch(seq[i], 5'd2, $sformatf("rr%0d", i));
            retire(5'd1, 1'b0, $sformatf("rr%0d_r1", i));
            retire(5'd0, 1'b1, $sformatf("rr%0d_r2", i));
            check_back_in_so($sformatf("rr%0d", i));
        end
    endtask

    task automatic test_quantum_zero();
        do_reset();
        quantum = 5'd0;
        dispatch(2'd1, 5'd1, "q0");
        quantum = 5'd7;
        retire(5'd0, 1'b1, "q0_r1");
        check_back_in_so("q0");
    endtask

    task automatic test_halt_and_last_process();
        do_reset();
        quantum = 5'd5;
        dispatch(2'd1, 5'd5, "halt");
        retire(5'd4, 1'b0, "halt_r1");
        halt_usuario = 1'b1;
        step();
        halt_usuario = 1'b0;
        total++;
        if (flag_faz_preempcao !== 1'b1 || processos_vivos !== 2'b10 || todos_terminados !== 1'b0)
            $display("FAIL halt_p1: flag=%0b vivos=%b todos=%0b, expected 1 10 0",
                     flag_faz_preempcao, processos_vivos, todos_terminados);
        else passed++;
        check_back_in_so("halt");
        quantum = 5'd1;
        dispatch(2'd2, 5'd1, "after_halt1");
        retire(5'd0, 1'b1, "after_halt1_r");
        check_back_in_so("after_halt1");
        dispatch(2'd2, 5'd1, "after_halt2");
        // HALT together with the expiring retire on the last live process
        halt_usuario   = 1'b1;
        instr_retirada = 1'b1;
        step();
        halt_usuario   = 1'b0;
        instr_retirada = 1'b0;
        total++;
        if (flag_faz_preempcao !== 1'b1 || processos_vivos !== 2'b00 || todos_terminados !== 1'b1 || jump_prog !== 2'd0)
            $display("FAIL halt_expire: flag=%0b vivos=%b todos=%0b jump=%0d, expected 1 00 1 0",
                     flag_faz_preempcao, processos_vivos, todos_terminados, jump_prog);
        else passed++;
        check_back_in_so("halt_expire");
        pedido_despacho = 1'b1;
        step();
        pedido_despacho = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (jump_prog !== 2'd0 || processo_atual !== 2'd0 || flag_faz_preempcao !== 1'b0 || todos_terminados !== 1'b1)
                $display("FAIL no_live_dispatch%0d: jump=%0d proc=%0d flag=%0b todos=%0b, expected 0 0 0 1",
                         i, jump_prog, processo_atual, flag_faz_preempcao, todos_terminados);
            else passed++;
            step();
        end
    endtask

    task automatic test_reset_mid_slice();
        do_reset();
        quantum = 5'd6;
        dispatch(2'd1, 5'd6, "mid");
        retire(5'd5, 1'b0, "mid_r1");
        retire(5'd4, 1'b0, "mid_r2");
        #1;
        reset = 1'b1;
        #1;
        total++;
        if (flag_faz_preempcao !== 1'b0 || jump_prog !== 2'd0 || processo_atual !== 2'd0 ||
            contador_quantum !== 5'd0 || processos_vivos !== 2'b11 || todos_terminados !== 1'b0)
            $display("FAIL reset_async: flag=%0b jump=%0d proc=%0d cnt=%0d vivos=%b todos=%0b, expected 0 0 0 0 11 0",
                     flag_faz_preempcao, jump_prog, processo_atual, contador_quantum,
                     processos_vivos, todos_terminados);
        else passed++;
        step();
        reset = 1'b0;
        dispatch(2'd1, 5'd6, "post_reset");
    endtask

    initial begin
        test_reset();
        test_basic_quantum();
        test_round_robin();
        test_quantum_zero();
        test_halt_and_last_process();
        test_reset_mid_slice();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
